alu_issue_stage: RTL

Issue stage sitting directly upstream of the 16-bit ALU. Accepts decoded instructions over a valid/ready handshake, selects and forwards operands, and translates the opcode to the ALU's 3-bit ALUOp. It drives registered FirstInput/SecondInput/ALUOp into the ALU and tracks each instruction's destination and flags through the ALU's one-cycle registered latency. It presents the completed result, with Zero-based branch resolution, to writeback.

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 16-bit ALU: decodes opcodes, forwards operands, and
// tracks each instruction through the ALU's one-cycle latency to writeback.
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int RADDR = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       InOpcode,
  input  logic [RADDR-1:0] InRsAddr,
  input  logic [RADDR-1:0] InRtAddr,
  input  logic [WIDTH-1:0] InRsData,
  input  logic [WIDTH-1:0] InRtData,
  input  logic [WIDTH-1:0] InImm,
  input  logic [RADDR-1:0] InDest,
  output logic [WIDTH-1:0] FirstInput,
  output logic [WIDTH-1:0] SecondInput,
  output logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  output logic             ResultValid,
  output logic [WIDTH-1:0] ResultData,
  output logic [RADDR-1:0] ResultDest,
  output logic             ResultWriteEn,
  output logic             BranchTaken,
  output logic             IllegalOp
);

  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_e;

  logic             iss_valid_q, ex_valid_q;
  logic             iss_we_q, ex_we_q;
  logic [RADDR-1:0] iss_dest_q, ex_dest_q;
  br_e              iss_br_q, ex_br_q;
  logic [WIDTH-1:0] first_q, second_q;
  logic [2:0]       aluop_q;
  logic             illegal_q;

  logic             iss_valid_d, iss_we_d;
  logic [RADDR-1:0] iss_dest_d;
  br_e              iss_br_d;
  logic [WIDTH-1:0] first_d, second_d;
  logic [2:0]       aluop_d;

  logic [2:0]       dec_op;
  logic             dec_we, dec_imm, dec_ill;
  br_e              dec_br;
  logic             hazard, accept, fwd_rs, fwd_rt;
  logic [WIDTH-1:0] rs_val, rt_val;

  always_comb begin
    dec_op  = 3'd0;
    dec_we  = 1'b0;
    dec_imm = 1'b0;
    dec_ill = 1'b0;
    dec_br  = BR_NONE;
    case (InOpcode)
      4'd0: ;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        dec_op = InOpcode[2:0];
        dec_we = 1'b1;
      end
      4'd8: begin
        dec_op  = 3'd1;
        dec_we  = 1'b1;
        dec_imm = 1'b1;
      end
      4'd9: begin
        dec_op = 3'd2;
        dec_br = BR_EQ;
      end
      4'd10: begin
        dec_op = 3'd2;
        dec_br = BR_NE;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // The ISSUE result is not available until next cycle, so a read of it must stall once.
  assign hazard  = iss_valid_q && iss_we_q &&
                   ((iss_dest_q == InRsAddr) || (!dec_imm && (iss_dest_q == InRtAddr)));
  assign InReady = !RST && !hazard;
  assign accept  = InValid && InReady;

  assign fwd_rs = ex_valid_q && ex_we_q && (ex_dest_q == InRsAddr);
  assign fwd_rt = ex_valid_q && ex_we_q && (ex_dest_q == InRtAddr);
  assign rs_val = fwd_rs ? AluResult : InRsData;
  assign rt_val = fwd_rt ? AluResult : InRtData;

  always_comb begin
    iss_valid_d = accept;
    iss_we_d    = accept && dec_we;
    iss_dest_d  = accept ? InDest : '0;
    iss_br_d    = accept ? dec_br : BR_NONE;
    first_d     = accept ? rs_val : '0;
    second_d    = accept ? (dec_imm ? InImm : rt_val) : '0;
    aluop_d     = accept ? dec_op : 3'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      iss_valid_q <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_dest_q  <= '0;
      iss_br_q    <= BR_NONE;
      ex_valid_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_dest_q   <= '0;
      ex_br_q     <= BR_NONE;
      first_q     <= '0;
      second_q    <= '0;
      aluop_q     <= 3'd0;
      illegal_q   <= 1'b0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_we_q    <= iss_we_d;
      iss_dest_q  <= iss_dest_d;
      iss_br_q    <= iss_br_d;
      ex_valid_q  <= iss_valid_q;
      ex_we_q     <= iss_we_q;
      ex_dest_q   <= iss_dest_q;
      ex_br_q     <= iss_br_q;
      first_q     <= first_d;
      second_q    <= second_d;
      aluop_q     <= aluop_d;
      if (accept && dec_ill) illegal_q <= 1'b1;
    end
  end

  assign FirstInput    = first_q;
  assign SecondInput   = second_q;
  assign ALUOp         = aluop_q;
  assign ResultValid   = ex_valid_q;
  assign ResultData    = AluResult;
  assign ResultDest    = ex_dest_q;
  assign ResultWriteEn = ex_valid_q && ex_we_q;
  assign BranchTaken   = ex_valid_q &&
                         (((ex_br_q == BR_EQ) && AluZero) || ((ex_br_q == BR_NE) && !AluZero));
  assign IllegalOp     = illegal_q;

endmodule
